quad_decoder_mc: RTL and testbench
==================================

# quad_decoder_mc

Multi-channel quadrature encoder decoder for the robotics cape motor interfaces. It replaces the single-channel 32-bit counter with a parametrised array of channels. Each channel adds a digital glitch filter, index-pulse zeroing, software clear and illegal-transition detection. An optional per-channel signed velocity measurement over a fixed sample window sits between the encoder pins and the register bank that exposes counts to the processor.

## Interface
- CHANNELS, 4: number of independent encoder channels (1..8).
- COUNT_W, 32: position counter width per channel (8..32).
- FILTER_LEN, 4: consecutive stable cycles required before a filtered input changes (1..255).
- VEL_PERIOD, 100000: velocity window length in clk cycles (≥2).
- VEL_W, 16: signed velocity result width per channel.

- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- in_a  in  CHANNELS  encoder phase A per channel, asynchronous.
- in_b  in  CHANNELS  encoder phase B per channel, asynchronous.
- in_i  in  CHANNELS  encoder index per channel, asynchronous.
- index_zero_en  in  CHANNELS  per channel: a filtered rising edge of in_i zeroes the count.
- clear  in  CHANNELS  per channel: synchronous count clear; also clears that channel's err.
- count  out  CHANNELS*COUNT_W  position counts; channel n occupies bits [n*COUNT_W +: COUNT_W].
- err  out  CHANNELS  sticky illegal-transition flag per channel.
- velocity  out  CHANNELS*VEL_W  signed edge count per window; channel n occupies bits [n*VEL_W +: VEL_W].
- vel_valid  out  1  one-cycle pulse when velocity updates.

## Operation
- Reset: count=0, err=0, velocity=0, vel_valid=0. Filter state is zeroed: filtered value 0, stability counter 0. Sync flops are zeroed. Window counter=0.
- Sync: in_a, in_b and in_i each pass through a 2-flop synchroniser. The output of the second flop is s.
- Filter, per signal, with filtered value f and counter c:
  - If s==f, then c<=0.
  - Else, if c==FILTER_LEN-1, then f<=s and c<=0.
  - Otherwise c<=c+1.
- Decode: compare {fa,fb} with the previous-cycle registered value {pa,pb}.
  - Exactly one bit changed: the count changes by one. Direction = fa ^ pb; 1 means +1, 0 means −1. The sequence 00→10→11→01→00 increments.
  - Both bits changed: illegal transition. err<=1 and the count is unchanged.
  - No change: hold.
- Count arithmetic wraps modulo 2^COUNT_W.
- Index: a rising edge is filtered fi=1 with previous value pi=0.
- Priority per channel, highest first:
  1. reset_n=0.
  2. clear: count<=0, err<=0.
  3. Index edge with index_zero_en set: count<=0. A coincident quadrature step is discarded.
  4. Quadrature step.
- An illegal transition in the same cycle as clear leaves err=0.
- err stays set until clear or reset.

## Timing
- Pin change stable before edge N: f updates at edge N+1+FILTER_LEN, and count/err update at edge N+2+FILTER_LEN.
- Pulses shorter than FILTER_LEN synchronised cycles are rejected completely.
- clear takes effect at the next clk edge. It is level-sensitive: holding clear high keeps count at 0.
- Channels are fully independent. Simultaneous events on different channels are all processed in the same cycle.

## Configuration
- QDEC_VELOCITY_EN defined:
  - Each channel has a signed VEL_W accumulator that counts +1/−1 per valid step.
  - A shared window counter runs from 0 to VEL_PERIOD-1.
  - On the cycle the window counter equals VEL_PERIOD-1, velocity<=accumulator plus that cycle's step, the accumulator resets to 0, and vel_valid=1 at the following edge.
  - The accumulator saturates at ±(2^(VEL_W-1)-1).
  - clear and index zeroing do not affect the accumulator.
- QDEC_VELOCITY_EN undefined: no accumulators or window counter; velocity is tied to 0 and vel_valid to 0.

## Test plan
- Reset, then CHANNELS=4 and FILTER_LEN=4: drive 8 forward steps on ch0, one per 20 cycles. Expect count[ch0]=8 and other channels 0, with each update 6 cycles after the pin change.
- Drive 3 reverse steps from 0 on ch1 with COUNT_W=32. Expect count=0xFFFFFFFD (wrap). err remains 0.
- Toggle ch2 A and B simultaneously. Expect err[2]=1 and the count unchanged. Then pulse clear[2] for 1 cycle: expect count=0 and err=0 at the next edge.
- Inject a 3-cycle glitch on in_a ch3 with FILTER_LEN=4. Expect no count change. Then hold the change for 4 cycles: expect one step.
- Set index_zero_en[0]=1 with count=57. Raise in_i for 10 cycles. Expect count=0 once, and counting resumes from 0. With index_zero_en=0, expect the count unaffected.
- With QDEC_VELOCITY_EN and VEL_PERIOD=1000: drive 25 forward steps within one window. Expect vel_valid pulse and velocity=25, then velocity=0 after an idle window.

Source files
------------

// File: rtl/quad_decoder_mc.sv
`default_nettype none
// ============================================================================
// quad_decoder_mc : multi-channel quadrature decoder with glitch filter,
// index zeroing, software clear and sticky illegal-transition flag.
// Optional windowed velocity measurement: define QDEC_VELOCITY_EN.
// Revision: 1.0
// ============================================================================
module quad_decoder_mc #(
  parameter int CHANNELS   = 4,
  parameter int COUNT_W    = 32,
  parameter int FILTER_LEN = 4,
  parameter int VEL_PERIOD = 100000,
  parameter int VEL_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [CHANNELS-1:0]         in_a,
  input  logic [CHANNELS-1:0]         in_b,
  input  logic [CHANNELS-1:0]         in_i,
  input  logic [CHANNELS-1:0]         index_zero_en,
  input  logic [CHANNELS-1:0]         clear,
  output logic [CHANNELS*COUNT_W-1:0] count,
  output logic [CHANNELS-1:0]         err,
  output logic [CHANNELS*VEL_W-1:0]   velocity,
  output logic                        vel_valid
);

  localparam int                FCNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

  if (CHANNELS < 1 || CHANNELS > 8 || COUNT_W < 8 || COUNT_W > 32 ||
      FILTER_LEN < 1 || FILTER_LEN > 255 || VEL_PERIOD < 2 || VEL_W < 2) begin : g_param_check
    $error("quad_decoder_mc: parameter out of range");
  end

  logic [CHANNELS-1:0] step_valid;
  logic [CHANNELS-1:0] step_up;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    // Signal bundles are ordered {index, b, a}.
    logic [2:0]             sync1_q, sync2_q;
    logic [2:0]             filt_q, filt_d;
    logic [2:0]             prev_q;
    logic [2:0][FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [COUNT_W-1:0]     count_q, count_d;
    logic                   err_q, err_d;
    logic [1:0]             delta;
    logic                   index_edge;

    always_comb begin
      filt_d = filt_q;
      fcnt_d = fcnt_q;
      for (int k = 0; k < 3; k++) begin
        if (sync2_q[k] == filt_q[k]) begin
          fcnt_d[k] = '0;
        end else if (fcnt_q[k] == FCNT_LAST) begin
          filt_d[k] = sync2_q[k];
          fcnt_d[k] = '0;
        end else begin
          fcnt_d[k] = fcnt_q[k] + 1'b1;
        end
      end
    end

    assign delta         = filt_q[1:0] ^ prev_q[1:0];
    assign step_valid[n] = ^delta;
    assign step_up[n]    = filt_q[0] ^ prev_q[1];
    assign index_edge    = filt_q[2] & ~prev_q[2];

    // An index zero wins over a coincident step; the step is dropped.
    always_comb begin
      count_d = count_q;
      err_d   = err_q | (&delta);
      if (clear[n]) begin
        count_d = '0;
        err_d   = 1'b0;
      end else if (index_edge && index_zero_en[n]) begin
        count_d = '0;
      end else if (step_valid[n]) begin
        count_d = step_up[n] ? count_q + 1'b1 : count_q - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        sync1_q <= '0;
        sync2_q <= '0;
        filt_q  <= '0;
        fcnt_q  <= '0;
        prev_q  <= '0;
        count_q <= '0;
        err_q   <= 1'b0;
      end else begin
        sync1_q <= {in_i[n], in_b[n], in_a[n]};
        sync2_q <= sync1_q;
        filt_q  <= filt_d;
        fcnt_q  <= fcnt_d;
        prev_q  <= filt_q;
        count_q <= count_d;
        err_q   <= err_d;
      end
    end

    assign count[n*COUNT_W +: COUNT_W] = count_q;
    assign err[n]                      = err_q;
  end

`ifdef QDEC_VELOCITY_EN
  localparam int               WIN_W    = $clog2(VEL_PERIOD);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_PERIOD - 1);
  localparam logic [VEL_W-1:0] VEL_MAX  = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic [VEL_W-1:0] VEL_MIN  = ~VEL_MAX + 1'b1;

  logic [WIN_W-1:0]               win_q, win_d;
  logic                           win_end;
  logic [CHANNELS-1:0][VEL_W-1:0] acc_q, acc_d, acc_next;
  logic [CHANNELS-1:0][VEL_W-1:0] vel_q, vel_d;
  logic                           vel_valid_q, vel_valid_d;

  // The closing cycle's own step is folded into the published value.
  always_comb begin
    win_end     = (win_q == WIN_LAST);
    win_d       = win_end ? '0 : win_q + 1'b1;
    vel_valid_d = win_end;
    acc_next    = acc_q;
    acc_d       = acc_q;
    vel_d       = vel_q;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (step_valid[ch]) begin
        if (step_up[ch] && acc_q[ch] != VEL_MAX) begin
          acc_next[ch] = acc_q[ch] + 1'b1;
        end else if (!step_up[ch] && acc_q[ch] != VEL_MIN) begin
          acc_next[ch] = acc_q[ch] - 1'b1;
        end
      end
      if (win_end) begin
        vel_d[ch] = acc_next[ch];
        acc_d[ch] = '0;
      end else begin
        acc_d[ch] = acc_next[ch];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win_q       <= '0;
      acc_q       <= '0;
      vel_q       <= '0;
      vel_valid_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      acc_q       <= acc_d;
      vel_q       <= vel_d;
      vel_valid_q <= vel_valid_d;
    end
  end

  assign velocity  = vel_q;
  assign vel_valid = vel_valid_q;
`else
  assign velocity  = '0;
  assign vel_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder_mc.sv
`default_nettype none
// ============================================================================
// tb_quad_decoder_mc : scoreboard bench for quad_decoder_mc; directed
// scenarios followed by randomized multi-channel stepping.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_quad_decoder_mc;
  localparam int CH  = 4;
  localparam int CW  = 32;
  localparam int FL  = 4;
  localparam int VP  = 1000;
  localparam int VW  = 16;
  localparam int LAT = FL + 3;   // drive (just after an edge) to count update

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [CH-1:0]    in_a = '0, in_b = '0, in_i = '0, index_zero_en = '0, clear = '0;
  logic [CH*CW-1:0] count;
  logic [CH-1:0]    err;
  logic [CH*VW-1:0] velocity;
  logic             vel_valid;

  quad_decoder_mc #(
    .CHANNELS(CH), .COUNT_W(CW), .FILTER_LEN(FL), .VEL_PERIOD(VP), .VEL_W(VW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_a(in_a), .in_b(in_b), .in_i(in_i),
    .index_zero_en(index_zero_en), .clear(clear), .count(count), .err(err),
    .velocity(velocity), .vel_valid(vel_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int at; logic [CH*CW-1:0] cnt; logic [CH-1:0] err; } snap_t;
  typedef struct { int at; int ch; int d; } step_t;

  // Reference model: quadrature phase 0..3 walks 00,10,11,01 as {a,b}.
  int            ph[CH];
  logic [CW-1:0] mpos[CH];
  logic          merr[CH];
  snap_t         exp_q[$];
  step_t         steps_q[$];
  logic [CH*CW-1:0] last_push_cnt = '0;
  logic [CH-1:0]    last_push_err = '0;

  int checks = 0, errors = 0;
  int rel_edge = 0;
  bit mon_en = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic push_snap(input int at);
    snap_t s;
    for (int c = 0; c < CH; c++) begin
      s.cnt[c*CW +: CW] = mpos[c];
      s.err[c]          = merr[c];
    end
    s.at = at;
    if (s.cnt !== last_push_cnt || s.err !== last_push_err) begin
      exp_q.push_back(s);
      last_push_cnt = s.cnt;
      last_push_err = s.err;
    end
  endtask

  task automatic drive_pins();
    for (int c = 0; c < CH; c++) begin
      in_a[c] = (ph[c] == 1 || ph[c] == 2);
      in_b[c] = (ph[c] >= 2);
    end
  endtask

  task automatic do_steps(input logic [CH-1:0] mask, input logic [CH-1:0] up);
    step_t st;
    for (int c = 0; c < CH; c++) begin
      if (mask[c]) begin
        if (up[c]) begin ph[c] = (ph[c] + 1) % 4; mpos[c] = mpos[c] + 1; end
        else       begin ph[c] = (ph[c] + 3) % 4; mpos[c] = mpos[c] - 1; end
        st.at = cyc + LAT; st.ch = c; st.d = up[c] ? 1 : -1;
        steps_q.push_back(st);
      end
    end
    drive_pins();
    push_snap(cyc + LAT);
  endtask

  task automatic do_illegal(input int c);
    ph[c]   = (ph[c] + 2) % 4;
    merr[c] = 1'b1;
    drive_pins();
    push_snap(cyc + LAT);
  endtask

  task automatic do_clear(input int c);
    clear[c] = 1'b1;
    mpos[c]  = '0;
    merr[c]  = 1'b0;
    push_snap(cyc + 1);
    tick(1);
    clear[c] = 1'b0;
  endtask

  // Count/err monitor: any change on the outputs must match the next expectation.
  logic [CH*CW-1:0] seen_cnt = '0;
  logic [CH-1:0]    seen_err = '0;
  snap_t            mon_s;
  always @(negedge clk) begin
    if (mon_en) begin
      if (count !== seen_cnt || err !== seen_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_update cyc=%0d count=%h err=%b, no update expected", cyc, count, err);
        end else begin
          mon_s = exp_q.pop_front();
          if (mon_s.at != cyc || mon_s.cnt !== count || mon_s.err !== err) begin
            errors++;
            $display("FAIL update cyc=%0d count=%h err=%b expected cyc=%0d count=%h err=%b",
                     cyc, count, err, mon_s.at, mon_s.cnt, mon_s.err);
          end
        end
        seen_cnt = count;
        seen_err = err;
      end
      if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        checks++;
        errors++;
        mon_s = exp_q.pop_front();
        $display("FAIL missed_update cyc=%0d expected at cyc=%0d count=%h err=%b", cyc, mon_s.at, mon_s.cnt, mon_s.err);
      end
    end
  end

  // Velocity monitor: windows close every VP edges counted from reset release.
  bit exp_v;
  int vsum;
  always @(negedge clk) begin
    if (mon_en) begin
`ifdef QDEC_VELOCITY_EN
      exp_v = (cyc >= rel_edge) && (((cyc - rel_edge + 1) % VP) == 0);
      if (exp_v || vel_valid !== 1'b0) begin
        checks++;
        if (vel_valid !== exp_v) begin
          errors++;
          $display("FAIL vel_valid cyc=%0d actual=%b expected=%b", cyc, vel_valid, exp_v);
        end else begin
          for (int c = 0; c < CH; c++) begin
            vsum = 0;
            for (int k = 0; k < steps_q.size(); k++)
              if (steps_q[k].ch == c && steps_q[k].at > cyc - VP && steps_q[k].at <= cyc)
                vsum += steps_q[k].d;
            checks++;
            if ($signed(velocity[c*VW +: VW]) != vsum) begin
              errors++;
              $display("FAIL velocity ch%0d cyc=%0d actual=%0d expected=%0d", c, cyc, $signed(velocity[c*VW +: VW]), vsum);
            end
          end
        end
      end
`else
      if (vel_valid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL vel_valid cyc=%0d actual=%b expected=0", cyc, vel_valid);
      end
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d run did not complete", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH-1:0] rmask, rup;
    int kind, rc;
    for (int c = 0; c < CH; c++) begin ph[c] = 0; mpos[c] = '0; merr[c] = 1'b0; end

    tick(5);
    check("reset_count", count, 0);
    check("reset_err", err, 0);
    check("reset_velocity", velocity, 0);
    check("reset_vel_valid", vel_valid, 0);
    reset_n  = 1'b1;
    rel_edge = cyc + 1;
    mon_en   = 1'b1;
    tick(2);

    for (int i = 0; i < 8; i++) begin do_steps(4'b0001, 4'b0001); tick(20); end
    check("ch0_fwd8", count[CW-1:0], 8);
    check("others_zero", count[CH*CW-1:CW], 0);

    for (int i = 0; i < 3; i++) begin do_steps(4'b0010, 4'b0000); tick(20); end
    check("ch1_wrap", count[2*CW-1:CW], 32'hFFFF_FFFD);
    check("no_err", err, 0);

    do_steps(4'b0100, 4'b0100); tick(12);
    do_steps(4'b0100, 4'b0100); tick(12);
    do_illegal(2); tick(20);
    check("ch2_err_set", err[2], 1);
    check("ch2_hold_on_illegal", count[3*CW-1:2*CW], 2);
    do_clear(2);
    check("ch2_clear_count", count[3*CW-1:2*CW], 0);
    check("ch2_clear_err", err[2], 0);
    tick(10);

    in_a[3] = 1'b1; tick(3);
    in_a[3] = 1'b0; tick(15);
    check("ch3_glitch_rejected", count[4*CW-1:3*CW], 0);
    do_steps(4'b1000, 4'b1000); tick(20);
    check("ch3_step_accepted", count[4*CW-1:3*CW], 1);

    for (int i = 0; i < 49; i++) begin do_steps(4'b0001, 4'b0001); tick(10); end
    check("ch0_57", count[CW-1:0], 57);
    index_zero_en[0] = 1'b1;
    in_i[0] = 1'b1;
    mpos[0] = '0;
    push_snap(cyc + LAT);
    tick(10);
    in_i[0] = 1'b0; tick(10);
    check("ch0_index_zero", count[CW-1:0], 0);
    do_steps(4'b0001, 4'b0001); tick(12);
    check("ch0_resume", count[CW-1:0], 1);
    index_zero_en[0] = 1'b0;
    in_i[0] = 1'b1; tick(10);
    in_i[0] = 1'b0; tick(10);
    check("ch0_index_disabled", count[CW-1:0], 1);

    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 9);
      rc   = $urandom_range(0, CH-1);
      if (kind == 0)      do_clear(rc);
      else if (kind == 1) do_illegal(rc);
      else begin
        rmask = CH'($urandom_range(1, (1 << CH) - 1));
        rup   = CH'($urandom);
        do_steps(rmask, rup);
      end
      tick($urandom_range(10, 16));
    end

`ifdef QDEC_VELOCITY_EN
    while (((cyc - rel_edge + 1) % VP) != 0) tick(1);
    for (int i = 0; i < 25; i++) begin do_steps(4'b0001, 4'b0001); tick(30); end
    while (((cyc - rel_edge + 1) % VP) != 0) tick(1);
    check("vel_25", velocity[VW-1:0], 25);
    tick(VP);
    check("vel_idle", velocity, 0);
`endif

    for (int k = 0; k < 100 && exp_q.size() > 0; k++) tick(1);
    check("scoreboard_drained", exp_q.size(), 0);
`ifndef QDEC_VELOCITY_EN
    check("velocity_tied_zero", velocity, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
